// File: rtl/dsp_pkg.sv
// Shared DSP defaults: sample/accumulator widths and the accumulate-and-dump state encoding.
package dsp_pkg;

  localparam int IN_WIDTH_DEF  = 16;
  localparam int ACC_WIDTH_DEF = 32;
  localparam int DECIM_W_DEF   = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } dump_state_e;

endpackage

// File: rtl/accum_dump_decimator.sv
// Accumulate-and-dump decimator: sums N signed samples and presents each sum behind a
// one-entry valid/ready holding register with a sticky overrun flag.
module accum_dump_decimator
  import dsp_pkg::*;
#(
  parameter int IN_WIDTH  = IN_WIDTH_DEF,
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int DECIM_W   = DECIM_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic [DECIM_W-1:0]   decim_n,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 overrun
);

  dump_state_e          state_q, state_d;
  logic [DECIM_W-1:0]   cnt_q, cnt_d;
  logic [DECIM_W-1:0]   n_lat_q, n_lat_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 overrun_q, overrun_d;

  logic [DECIM_W-1:0]   n_eff;
  logic [ACC_WIDTH-1:0] sext;
  logic [ACC_WIDTH-1:0] dump_val;
  logic                 dump;

  assign n_eff = (decim_n == '0) ? DECIM_W'(1) : decim_n;
  assign sext  = ACC_WIDTH'($signed(in_data));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_lat_d     = n_lat_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;
    dump        = 1'b0;
    dump_val    = acc_q + sext;

    unique case (state_q)
      ST_IDLE: begin
        // A new period starts from the sample alone; any stale acc is not summed in.
        dump_val = sext;
        if (in_valid) begin
          n_lat_d = n_eff;
          acc_d   = sext;
          if (n_eff == DECIM_W'(1)) begin
            dump  = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d   = DECIM_W'(1);
            state_d = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d = acc_q + sext;
          cnt_d = cnt_q + DECIM_W'(1);
          if (cnt_q == n_lat_q - DECIM_W'(1)) begin
            dump    = 1'b1;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (dump) begin
      out_data_d  = dump_val;
      out_valid_d = 1'b1;
      if (out_valid_q && !out_ready) overrun_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Flush wins over everything computed above; held output data and n_lat are kept.
    if (clear) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      acc_d       = '0;
      n_lat_d     = n_lat_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      n_lat_q     <= DECIM_W'(1);
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_lat_q     <= n_lat_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_accum_dump_decimator.sv
// Directed bench for accum_dump_decimator: vector table plus hand-written reset sequence.
module tb_accum_dump_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic [7:0]  decim_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        clr;
    logic [7:0]  n;
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic        chkd;
    logic        eo;
  } vec_t;

  vec_t vq[$];

  accum_dump_decimator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .decim_n  (decim_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic add(input logic clr, input logic [7:0] n, input logic v, input logic [15:0] d,
                     input logic rdy, input logic ev, input logic [31:0] ed, input logic chkd,
                     input logic eo);
    vec_t t;
    t.clr = clr; t.n = n; t.v = v; t.d = d; t.rdy = rdy;
    t.ev = ev; t.ed = ed; t.chkd = chkd; t.eo = eo;
    vq.push_back(t);
  endtask

  task automatic step(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // N=4, 1..4 back to back
    add(0, 4, 1, 16'd1, 1, 0, 0, 0, 0);
    add(0, 4, 1, 16'd2, 1, 0, 0, 0, 0);
    add(0, 4, 1, 16'd3, 1, 0, 0, 0, 0);
    add(0, 4, 1, 16'd4, 1, 1, 32'd10, 1, 0);
    add(0, 4, 0, 16'd0, 1, 0, 32'd10, 1, 0);
    // N=2, most-negative samples
    add(0, 2, 1, 16'h8000, 1, 0, 0, 0, 0);
    add(0, 2, 1, 16'h8000, 1, 1, 32'hFFFF0000, 1, 0);
    add(0, 2, 0, 16'd0, 1, 0, 0, 0, 0);
    // N=1 continuous dump with consume+reload
    add(0, 1, 1, 16'h8000, 1, 1, 32'hFFFF8000, 1, 0);
    add(0, 1, 1, 16'h8000, 1, 1, 32'hFFFF8000, 1, 0);
    add(0, 1, 1, 16'h8000, 1, 1, 32'hFFFF8000, 1, 0);
    add(0, 1, 0, 16'd0, 1, 0, 0, 0, 0);
    // N=0 treated as 1
    add(0, 0, 1, 16'd7, 1, 1, 32'd7, 1, 0);
    add(0, 0, 0, 16'd0, 1, 0, 0, 0, 0);
    // N=3 with bubbles: acc holds across idle cycles
    add(0, 3, 1, 16'd2, 1, 0, 0, 0, 0);
    add(0, 3, 0, 16'd0, 1, 0, 0, 0, 0);
    add(0, 3, 1, 16'd3, 1, 0, 0, 0, 0);
    add(0, 3, 0, 16'd0, 1, 0, 0, 0, 0);
    add(0, 3, 1, 16'd4, 1, 1, 32'd9, 1, 0);
    add(0, 3, 0, 16'd0, 1, 0, 32'd9, 1, 0);
    // N=2 with stalled consumer: hold, overwrite, sticky overrun
    add(0, 2, 1, 16'd5, 0, 0, 0, 0, 0);
    add(0, 2, 1, 16'd5, 0, 1, 32'd10, 1, 0);
    add(0, 2, 1, 16'd7, 0, 1, 32'd10, 1, 0);
    add(0, 2, 1, 16'd7, 0, 1, 32'd14, 1, 1);
    add(0, 2, 0, 16'd0, 1, 0, 32'd14, 1, 1);
    add(0, 2, 0, 16'd0, 0, 0, 32'd14, 1, 1);
    // clear beats a coincident sample
    add(1, 2, 1, 16'd100, 1, 0, 32'd14, 1, 0);
    add(0, 2, 1, 16'd1, 1, 0, 0, 0, 0);
    add(0, 2, 1, 16'd2, 1, 1, 32'd3, 1, 0);
    add(0, 2, 0, 16'd0, 1, 0, 0, 0, 0);
    // decim_n change mid-period applies to the next period only
    add(0, 4, 1, 16'd1, 1, 0, 0, 0, 0);
    add(0, 4, 1, 16'd2, 1, 0, 0, 0, 0);
    add(0, 2, 1, 16'd3, 1, 0, 0, 0, 0);
    add(0, 2, 1, 16'd4, 1, 1, 32'd10, 1, 0);
    add(0, 2, 1, 16'd5, 1, 0, 0, 0, 0);
    add(0, 2, 1, 16'd6, 1, 1, 32'd11, 1, 0);
    add(0, 2, 0, 16'd0, 1, 0, 32'd11, 1, 0);

    rst_n = 1'b0; clear = 1'b0; decim_n = 8'd4; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    foreach (vq[i]) begin
      clear     = vq[i].clr;
      decim_n   = vq[i].n;
      out_ready = vq[i].rdy;
      step(vq[i].v, vq[i].d);
      check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vq[i].ev));
      check($sformatf("v%0d_overrun", i), 32'(overrun), 32'(vq[i].eo));
      if (vq[i].chkd) check($sformatf("v%0d_out_data", i), out_data, vq[i].ed);
    end

    // Reset mid-period: partial sum dropped, next period starts fresh
    clear = 1'b0; decim_n = 8'd4; out_ready = 1'b1;
    step(1, 16'd1);
    step(1, 16'd1);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_data", out_data, 32'd0);
    check("rst_mid_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 16'd1);
    step(1, 16'd1);
    step(1, 16'd1);
    check("rst_after3_out_valid", 32'(out_valid), 32'd0);
    step(1, 16'd1);
    check("rst_after4_out_valid", 32'(out_valid), 32'd1);
    check("rst_after4_out_data", out_data, 32'd4);
    step(0, 16'd0);
    check("rst_final_out_valid", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
